// File: rtl/hs_npu_memory_responder.sv
// hs_npu_memory_responder
//
// Memory-side responder for the NPU line interface. It turns one NPU line
// read or line write into WORDS_PER_LINE word transactions on a pipelined
// Avalon-MM style master port.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   npu_read_ready_i    - NPU wants the line at npu_address_i
//   npu_address_i       - line byte address (shared by reads and writes)
//   npu_read_valid_o    - one-cycle pulse, npu_read_data_o holds the line
//   npu_read_data_o     - read line, word k at bits [32k +: 32]
//   npu_write_valid_i   - NPU presents a write line
//   npu_write_data_i    - write line, word k at bits [32k +: 32]
//   npu_write_ready_o   - responder is idle and can take a write line
//   avm_*               - word-wide master port (waitrequest / readdatavalid)
module hs_npu_memory_responder #(
  parameter int SIZE           = 8,
  parameter int WORDS_PER_LINE = SIZE * 8 / 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         npu_read_ready_i,
  input  logic [ADDR_WIDTH-1:0]        npu_address_i,
  output logic                         npu_read_valid_o,
  output logic [32*WORDS_PER_LINE-1:0] npu_read_data_o,
  input  logic                         npu_write_valid_i,
  input  logic [32*WORDS_PER_LINE-1:0] npu_write_data_i,
  output logic                         npu_write_ready_o,
  output logic [ADDR_WIDTH-1:0]        avm_address,
  output logic                         avm_read,
  output logic                         avm_write,
  output logic [31:0]                  avm_writedata,
  input  logic                         avm_waitrequest,
  input  logic [31:0]                  avm_readdata,
  input  logic                         avm_readdatavalid
);

  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE,
    WR_ISSUE
  } state_t;

  state_t                          state;
  logic [ADDR_WIDTH-1:0]           base;
  logic [CW-1:0]                   issue_cnt;
  logic [CW-1:0]                   ret_cnt;
  logic [CW-1:0]                   wr_cnt;
  logic [WORDS_PER_LINE-1:0][31:0] rd_line;
  logic [WORDS_PER_LINE-1:0][31:0] wr_line;

  // Line sequencer. Reads issue and absorb returns concurrently; since the
  // interconnect returns words in issue order, ret_cnt alone selects the
  // destination word. The return update is placed after the issue update so
  // that completing the line always wins the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      wr_cnt    <= '0;
      rd_line   <= '0;
      wr_line   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Writes take priority; a concurrent read is picked up once the
          // write line has drained and we are back here.
          if (npu_write_valid_i) begin
            base    <= npu_address_i & ALIGN_MASK;
            wr_line <= npu_write_data_i;
            wr_cnt  <= '0;
            state   <= WR_ISSUE;
          end else if (npu_read_ready_i) begin
            base      <= npu_address_i & ALIGN_MASK;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= RD_ISSUE;
          end
        end

        RD_ISSUE, RD_WAIT: begin
          if (state == RD_ISSUE && !avm_waitrequest) begin
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == LAST_WORD) begin
              state <= RD_WAIT;
            end
          end
          if (avm_readdatavalid) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              if (ret_cnt == CW'(k)) begin
                rd_line[k] <= avm_readdata;
              end
            end
            ret_cnt <= ret_cnt + CW'(1);
            if (ret_cnt == LAST_WORD) begin
              state <= RD_DONE;
            end
          end
        end

        // The line is offered for exactly one cycle; if the NPU is no longer
        // asking for it, it is dropped.
        RD_DONE: begin
          state <= IDLE;
        end

        WR_ISSUE: begin
          if (!avm_waitrequest) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST_WORD) begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus request decode. Everything here depends only on registered state and
  // counters, so address and data stay frozen while waitrequest is high.
  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state)
      RD_ISSUE: begin
        avm_read    = 1'b1;
        avm_address = base + (ADDR_WIDTH'(issue_cnt) << 2);
      end
      WR_ISSUE: begin
        avm_write   = 1'b1;
        avm_address = base + (ADDR_WIDTH'(wr_cnt) << 2);
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
          if (wr_cnt == CW'(k)) begin
            avm_writedata = wr_line[k];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Write-ready is masked by reset so that every output reads 0 while reset
  // is held, even though the FSM already sits in IDLE.
  assign npu_write_ready_o = (state == IDLE) && !rst;
  assign npu_read_valid_o  = (state == RD_DONE) && npu_read_ready_i;
  assign npu_read_data_o   = rd_line;

endmodule
